// File: rtl/stdp_update_h1.sv
// Pair-based STDP weight updater: tracks spike ages, addresses two external
// registered LUTs, then applies a clamped weight change three cycles after a step.
module stdp_update_h1 #(
   parameter int unsigned  W    = 24,
   parameter logic [W-1:0] WMAX = W'(24'h00FFFF),
   parameter logic [W-1:0] WMIN = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         step,
   input  logic         pre_spike,
   input  logic         post_spike,
   input  logic         load,
   input  logic [W-1:0] w_in,
   output logic [7:0]   lutp_addr,
   output logic [7:0]   lutm_addr,
   input  logic [W-1:0] lutp_data,
   input  logic [W-1:0] lutm_data,
   output logic [W-1:0] weight,
   output logic         upd_valid,
   output logic         busy,
   output logic         ovf
);

   typedef enum logic [1:0] {StIdle, StLookup, StApply} state_e;

   state_e         state_q, state_d;
   logic [7:0]     pre_age_q, pre_age_d;
   logic [7:0]     post_age_q, post_age_d;
   logic           pre_seen_q, pre_seen_d;
   logic           post_seen_q, post_seen_d;
   logic [7:0]     lutp_addr_q, lutp_addr_d;
   logic [7:0]     lutm_addr_q, lutm_addr_d;
   logic [W-1:0]   weight_q, weight_d;
   logic           upd_valid_q, upd_valid_d;
   logic           ovf_q, ovf_d;

   logic [7:0]     dt_pre, dt_post;
   logic signed [W+1:0] sum;
   logic signed [W+1:0] wmax_ext, wmin_ext;

   // Two extra bits keep the sum exact across both overflow and underflow.
   assign sum = $signed({2'b00, weight_q}) + $signed({2'b00, lutp_data})
              - $signed({2'b00, lutm_data});
   assign wmax_ext = $signed({2'b00, WMAX});
   assign wmin_ext = $signed({2'b00, WMIN});

   assign dt_pre  = (post_age_q == 8'hFF) ? 8'hFF : post_age_q + 8'd1;
   assign dt_post = (pre_age_q == 8'hFF) ? 8'hFF : pre_age_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      pre_age_d   = pre_age_q;
      post_age_d  = post_age_q;
      pre_seen_d  = pre_seen_q;
      post_seen_d = post_seen_q;
      lutp_addr_d = lutp_addr_q;
      lutm_addr_d = lutm_addr_q;
      weight_d    = weight_q;
      upd_valid_d = 1'b0;
      ovf_d       = ovf_q;

      // A step is dropped whenever it cannot be accepted: busy, or colliding with load.
      if (step && ((state_q != StIdle) || load)) begin
         ovf_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (load) begin
               weight_d = w_in;
            end else if (step) begin
               pre_age_d   = pre_spike  ? 8'd0
                           : ((pre_age_q == 8'hFF) ? 8'hFF : pre_age_q + 8'd1);
               post_age_d  = post_spike ? 8'd0
                           : ((post_age_q == 8'hFF) ? 8'hFF : post_age_q + 8'd1);
               // Seen flags update after addressing, so same-step pairs do not match.
               lutp_addr_d = (post_spike && pre_seen_q) ? dt_post : 8'd0;
               lutm_addr_d = (pre_spike && post_seen_q) ? dt_pre : 8'd0;
               pre_seen_d  = pre_seen_q | pre_spike;
               post_seen_d = post_seen_q | post_spike;
               if (pre_spike || post_spike) begin
                  state_d = StLookup;
               end
            end
         end
         StLookup: begin
            state_d = StApply;
         end
         StApply: begin
            if (sum > wmax_ext) begin
               weight_d = WMAX;
            end else if (sum < wmin_ext) begin
               weight_d = WMIN;
            end else begin
               weight_d = sum[W-1:0];
            end
            upd_valid_d = 1'b1;
            lutp_addr_d = 8'd0;
            lutm_addr_d = 8'd0;
            state_d     = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         pre_age_q   <= 8'd0;
         post_age_q  <= 8'd0;
         pre_seen_q  <= 1'b0;
         post_seen_q <= 1'b0;
         lutp_addr_q <= 8'd0;
         lutm_addr_q <= 8'd0;
         weight_q    <= '0;
         upd_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pre_age_q   <= pre_age_d;
         post_age_q  <= post_age_d;
         pre_seen_q  <= pre_seen_d;
         post_seen_q <= post_seen_d;
         lutp_addr_q <= lutp_addr_d;
         lutm_addr_q <= lutm_addr_d;
         weight_q    <= weight_d;
         upd_valid_q <= upd_valid_d;
         ovf_q       <= ovf_d;
      end
   end

   assign lutp_addr = lutp_addr_q;
   assign lutm_addr = lutm_addr_q;
   assign weight    = weight_q;
   assign upd_valid = upd_valid_q;
   assign busy      = (state_q != StIdle);
   assign ovf       = ovf_q;

endmodule
